// File: rtl/bp_update_unit.sv
// Retire-side gshare PHT training, speculative GHR and mispredict flush.
// Optional counters: define BP_UPDATE_STATS_EN.
module bp_update_unit #(
  parameter int GHR_W  = 5,
  parameter int ADDR_W = 8,
  parameter int TAG_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              update_signal_R,
  input  logic              prediction_R,
  input  logic              actual_outcome_R,
  input  logic [GHR_W-1:0]  ghr_R,
  input  logic [TAG_W-1:0]  tag_R,
  input  logic [ADDR_W-1:0] next_addr_R,
  input  logic [ADDR_W-1:0] b_addr_R,
  input  logic              f_valid,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_prediction,
  output logic [GHR_W-1:0]  f_ghr,
  output logic              flush,
  output logic [ADDR_W-1:0] redirect_addr,
`ifdef BP_UPDATE_STATS_EN
  output logic [TAG_W-1:0]  flush_tag,
  output logic [15:0]       br_count,
  output logic [15:0]       mispred_count
`else
  output logic [TAG_W-1:0]  flush_tag
`endif
);

  localparam int DEPTH = 1 << GHR_W;

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } state_t;

  state_t           state;
  logic [GHR_W-1:0] spec_ghr;
  logic [1:0]       pht [DEPTH];

  logic [GHR_W-1:0] upd_idx;
  logic [GHR_W-1:0] lk_idx;
  logic             accept;
  logic             mispred;
  logic [1:0]       ctr_q;
  logic [1:0]       ctr_d;
  logic             unused_bits;

  // Upper address bits never reach the index.
  assign unused_bits = ^{b_addr_R[ADDR_W-1:GHR_W],
                         f_addr[ADDR_W-1:GHR_W]};

  // Index hashing and accept/mispredict qualification.
  always_comb begin
    upd_idx = b_addr_R[GHR_W-1:0] ^ ghr_R;
    lk_idx  = f_addr[GHR_W-1:0] ^ spec_ghr;
    accept  = update_signal_R && (state == IDLE);
    mispred = accept && (prediction_R != actual_outcome_R);
  end

  // Fetch lookup sees the pre-edge table, no bypass.
  always_comb begin
    f_prediction = pht[lk_idx][1];
    f_ghr        = spec_ghr;
  end

  // Saturating 2-bit counter next value.
  always_comb begin
    ctr_q = pht[upd_idx];
    ctr_d = ctr_q;
    if (actual_outcome_R) begin
      if (ctr_q != 2'b11) ctr_d = ctr_q + 2'd1;
    end else begin
      if (ctr_q != 2'b00) ctr_d = ctr_q - 2'd1;
    end
  end

  // Pattern history table; wrong-path updates in FLUSH are dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) pht[i] <= 2'b01;
    end else if (accept) begin
      pht[upd_idx] <= ctr_d;
    end
  end

  // Recovery FSM with registered flush, redirect and GHR.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      flush         <= 1'b0;
      redirect_addr <= '0;
      flush_tag     <= '0;
      spec_ghr      <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (mispred) begin
            state         <= FLUSH;
            flush         <= 1'b1;
            redirect_addr <= next_addr_R;
            flush_tag     <= tag_R;
            spec_ghr      <= {ghr_R[GHR_W-2:0],
                              actual_outcome_R};
          end else if (f_valid) begin
            spec_ghr <= {spec_ghr[GHR_W-2:0],
                         f_prediction};
          end
        end
        FLUSH: begin
          state <= IDLE;
          flush <= 1'b0;
        end
        default: begin
          state <= IDLE;
          flush <= 1'b0;
        end
      endcase
    end
  end

`ifdef BP_UPDATE_STATS_EN
  // Saturating branch and mispredict event counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      br_count      <= '0;
      mispred_count <= '0;
    end else begin
      if (accept && br_count != 16'hFFFF)
        br_count <= br_count + 16'd1;
      if (mispred && mispred_count != 16'hFFFF)
        mispred_count <= mispred_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_bp_update_unit.sv
// Directed vector bench for bp_update_unit.
// Table of per-cycle vectors plus a reset-during-flush sequence.
module tb_bp_update_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       update_signal_R;
  logic       prediction_R;
  logic       actual_outcome_R;
  logic [4:0] ghr_R;
  logic [4:0] tag_R;
  logic [7:0] next_addr_R;
  logic [7:0] b_addr_R;
  logic       f_valid;
  logic [7:0] f_addr;
  logic       f_prediction;
  logic [4:0] f_ghr;
  logic       flush;
  logic [7:0] redirect_addr;
  logic [4:0] flush_tag;
`ifdef BP_UPDATE_STATS_EN
  logic [15:0] br_count;
  logic [15:0] mispred_count;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  bp_update_unit dut (
    .clk              (clk),
    .rst              (rst),
    .update_signal_R  (update_signal_R),
    .prediction_R     (prediction_R),
    .actual_outcome_R (actual_outcome_R),
    .ghr_R            (ghr_R),
    .tag_R            (tag_R),
    .next_addr_R      (next_addr_R),
    .b_addr_R         (b_addr_R),
    .f_valid          (f_valid),
    .f_addr           (f_addr),
    .f_prediction     (f_prediction),
    .f_ghr            (f_ghr),
    .flush            (flush),
    .redirect_addr    (redirect_addr),
`ifdef BP_UPDATE_STATS_EN
    .flush_tag        (flush_tag),
    .br_count         (br_count),
    .mispred_count    (mispred_count)
`else
    .flush_tag        (flush_tag)
`endif
  );

  typedef struct {
    logic       upd;
    logic       pred;
    logic       out;
    logic [4:0] ghr;
    logic [4:0] tag;
    logic [7:0] naddr;
    logic [7:0] baddr;
    logic       fv;
    logic [7:0] faddr;
    logic       e_pred;
    logic       e_flush;
    logic [7:0] e_redir;
    logic [4:0] e_tag;
    logic [4:0] e_ghr;
  } vec_t;

  vec_t vt [22];

  function automatic vec_t mk(
    logic upd, logic pred, logic out,
    logic [4:0] ghr, logic [4:0] tag,
    logic [7:0] naddr, logic [7:0] baddr,
    logic fv, logic [7:0] faddr,
    logic e_pred, logic e_flush,
    logic [7:0] e_redir, logic [4:0] e_tag,
    logic [4:0] e_ghr);
    vec_t v;
    v.upd = upd; v.pred = pred; v.out = out;
    v.ghr = ghr; v.tag = tag;
    v.naddr = naddr; v.baddr = baddr;
    v.fv = fv; v.faddr = faddr;
    v.e_pred = e_pred; v.e_flush = e_flush;
    v.e_redir = e_redir; v.e_tag = e_tag;
    v.e_ghr = e_ghr;
    return v;
  endfunction

  task automatic chk(string name, int idx,
                     logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s [%0d]: got %0h expected %0h",
               name, idx, act, exp);
    end
  endtask

  task automatic idle_inputs();
    update_signal_R  = 1'b0;
    prediction_R     = 1'b0;
    actual_outcome_R = 1'b0;
    ghr_R            = '0;
    tag_R            = '0;
    next_addr_R      = '0;
    b_addr_R         = '0;
    f_valid          = 1'b0;
    f_addr           = '0;
  endtask

  initial begin
    // reset / idle lookups
    vt[0]  = mk(0,0,0,5'h00,5'h00,8'h00,8'h00,0,8'h00, 0,0,8'h00,5'h00,5'h00);
    vt[1]  = mk(0,0,0,5'h00,5'h00,8'h00,8'h00,0,8'h1F, 0,0,8'h00,5'h00,5'h00);
    // training mispredict at index 3
    vt[2]  = mk(1,0,1,5'h00,5'h0A,8'h40,8'h03,0,8'h00, 0,1,8'h40,5'h0A,5'h01);
    // FLUSH cycle: f_valid ignored, lookup idx 3 = 10
    vt[3]  = mk(0,0,0,5'h00,5'h00,8'h00,8'h00,1,8'h02, 1,0,8'h40,5'h0A,5'h01);
    vt[4]  = mk(0,0,0,5'h00,5'h00,8'h00,8'h00,0,8'h02, 1,0,8'h40,5'h0A,5'h01);
    // five correct taken updates at index 5
    vt[5]  = mk(1,1,1,5'h00,5'h00,8'h00,8'h05,0,8'h04, 0,0,8'h40,5'h0A,5'h01);
    vt[6]  = mk(1,1,1,5'h00,5'h00,8'h00,8'h05,0,8'h04, 1,0,8'h40,5'h0A,5'h01);
    vt[7]  = mk(1,1,1,5'h00,5'h00,8'h00,8'h05,0,8'h04, 1,0,8'h40,5'h0A,5'h01);
    vt[8]  = mk(1,1,1,5'h00,5'h00,8'h00,8'h05,0,8'h04, 1,0,8'h40,5'h0A,5'h01);
    vt[9]  = mk(1,1,1,5'h00,5'h00,8'h00,8'h05,0,8'h04, 1,0,8'h40,5'h0A,5'h01);
    // two decrements: 11 -> 10 -> 01
    vt[10] = mk(1,0,0,5'h00,5'h00,8'h00,8'h05,0,8'h04, 1,0,8'h40,5'h0A,5'h01);
    vt[11] = mk(1,0,0,5'h00,5'h00,8'h00,8'h05,0,8'h04, 1,0,8'h40,5'h0A,5'h01);
    vt[12] = mk(0,0,0,5'h00,5'h00,8'h00,8'h00,0,8'h04, 0,0,8'h40,5'h0A,5'h01);
    // decrement to 00 then hold at 00
    vt[13] = mk(1,0,0,5'h00,5'h00,8'h00,8'h05,0,8'h04, 0,0,8'h40,5'h0A,5'h01);
    vt[14] = mk(1,0,0,5'h00,5'h00,8'h00,8'h05,0,8'h04, 0,0,8'h40,5'h0A,5'h01);
    vt[15] = mk(0,0,0,5'h00,5'h00,8'h00,8'h00,0,8'h04, 0,0,8'h40,5'h0A,5'h01);
    // speculative shifts in IDLE
    vt[16] = mk(0,0,0,5'h00,5'h00,8'h00,8'h00,1,8'h04, 0,0,8'h40,5'h0A,5'h02);
    vt[17] = mk(0,0,0,5'h00,5'h00,8'h00,8'h00,1,8'h01, 1,0,8'h40,5'h0A,5'h05);
    // mispredict plus f_valid: restore wins
    vt[18] = mk(1,1,0,5'h16,5'h15,8'h88,8'h00,1,8'h00, 0,1,8'h88,5'h15,5'h0C);
    // shadow: opposite-outcome update and fetch ignored
    vt[19] = mk(1,0,1,5'h16,5'h07,8'h99,8'h00,1,8'h1A, 0,0,8'h88,5'h15,5'h0C);
    // index 22 must still be 00: one increment leaves it 01
    vt[20] = mk(1,1,1,5'h16,5'h00,8'h00,8'h00,0,8'h1A, 0,0,8'h88,5'h15,5'h0C);
    vt[21] = mk(0,0,0,5'h00,5'h00,8'h00,8'h00,0,8'h1A, 0,0,8'h88,5'h15,5'h0C);

    idle_inputs();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_flush", 0, 32'(flush), 32'h0);
    chk("rst_ghr", 0, 32'(f_ghr), 32'h0);
    chk("rst_redir", 0, 32'(redirect_addr), 32'h0);
    chk("rst_tag", 0, 32'(flush_tag), 32'h0);
`ifdef BP_UPDATE_STATS_EN
    chk("rst_br", 0, 32'(br_count), 32'h0);
    chk("rst_mis", 0, 32'(mispred_count), 32'h0);
`endif
    for (int a = 0; a < 32; a++) begin
      f_addr = 8'(a);
      #1;
      chk("rst_pred", a, 32'(f_prediction), 32'h0);
    end

    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      update_signal_R  = vt[i].upd;
      prediction_R     = vt[i].pred;
      actual_outcome_R = vt[i].out;
      ghr_R            = vt[i].ghr;
      tag_R            = vt[i].tag;
      next_addr_R      = vt[i].naddr;
      b_addr_R         = vt[i].baddr;
      f_valid          = vt[i].fv;
      f_addr           = vt[i].faddr;
      #1;
      chk("f_pred", i, 32'(f_prediction), 32'(vt[i].e_pred));
      @(posedge clk);
      #1;
      chk("flush", i, 32'(flush), 32'(vt[i].e_flush));
      chk("redir", i, 32'(redirect_addr), 32'(vt[i].e_redir));
      chk("ftag", i, 32'(flush_tag), 32'(vt[i].e_tag));
      chk("f_ghr", i, 32'(f_ghr), 32'(vt[i].e_ghr));
    end

`ifdef BP_UPDATE_STATS_EN
    // accepted: 2,5-11,13,14,18,20 = 12; mispredicts: 2,18
    chk("br_cnt", 0, 32'(br_count), 32'd12);
    chk("mis_cnt", 0, 32'(mispred_count), 32'd2);
`endif

    // reset asserted while flush is high
    @(negedge clk);
    idle_inputs();
    update_signal_R  = 1'b1;
    prediction_R     = 1'b1;
    actual_outcome_R = 1'b0;
    b_addr_R         = 8'h03;
    tag_R            = 5'h1E;
    next_addr_R      = 8'h77;
    @(posedge clk);
    #1;
    chk("mid_flush", 0, 32'(flush), 32'h1);
    chk("mid_redir", 0, 32'(redirect_addr), 32'h77);
    idle_inputs();
    #2;
    rst = 1'b0;
    #1;
    chk("async_flush", 0, 32'(flush), 32'h0);
    chk("async_ghr", 0, 32'(f_ghr), 32'h0);
    chk("async_redir", 0, 32'(redirect_addr), 32'h0);
    chk("async_tag", 0, 32'(flush_tag), 32'h0);
`ifdef BP_UPDATE_STATS_EN
    chk("async_br", 0, 32'(br_count), 32'h0);
    chk("async_mis", 0, 32'(mispred_count), 32'h0);
`endif
    @(negedge clk);
    rst = 1'b1;
    // index 5 was 00; after reset it is 01, one taken makes 10
    update_signal_R  = 1'b1;
    prediction_R     = 1'b1;
    actual_outcome_R = 1'b1;
    b_addr_R         = 8'h05;
    f_addr           = 8'h05;
    #1;
    chk("post_pred0", 0, 32'(f_prediction), 32'h0);
    @(posedge clk);
    #1;
    update_signal_R = 1'b0;
    #1;
    chk("post_pred1", 0, 32'(f_prediction), 32'h1);
    chk("post_flush", 0, 32'(flush), 32'h0);
`ifdef BP_UPDATE_STATS_EN
    chk("post_br", 0, 32'(br_count), 32'h1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
